// File: rtl/axi_lite_mem_ctrl.sv
// axi_lite_mem_ctrl
//   AXI4-Lite slave that fronts four 8-bit byte-lane memories acting as one
//   32-bit word memory. Writes become a single-cycle lane write pulse; reads
//   register the combinational lane read data one cycle after the address is
//   presented. Write and read channels run independently and concurrently.
//
//   Ports
//     clk, rst_n                 clock (rising edge), synchronous active-low reset
//     s_axi_aw* / s_axi_w*       write address / write data channels
//     s_axi_b*                   write response channel
//     s_axi_ar* / s_axi_r*       read address / read data channels
//     mem_waddr/wdata/we/be      byte-lane write port (lane n = bits [8n+7:8n])
//     mem_raddr / mem_rdata      byte-lane read port (read data is combinational)
//
//   Optional feature: define AXI_LITE_MEM_CTRL_RANGE_CHECK_EN to reject word
//   indices >= C_MEMORY_SIZE with SLVERR (no lane write, read data 0).
module axi_lite_mem_ctrl #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_MEMORY_SIZE      = 512
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   mem_waddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
  output logic                            mem_we,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_be,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   mem_raddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int StrbW = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_LITE_MEM_CTRL_RANGE_CHECK_EN
  localparam bit RangeCheckEn = 1'b1;
`else
  localparam bit RangeCheckEn = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

  // Held low through reset so every ready output reads 0 while rst_n is
  // asserted; readies come up the cycle after reset is released.
  logic out_en_q;

  // ---------------- write channel ----------------
  wstate_e          w_state_q, w_state_d;
  logic             aw_held_q, aw_held_d;
  logic             w_held_q, w_held_d;
  logic [AW-1:0]    awaddr_q, awaddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [StrbW-1:0] wstrb_q, wstrb_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             aw_hs, w_hs, w_oor;
  logic [AW-1:0]    aw_word;

  // ---------------- read channel ----------------
  rstate_e          r_state_q, r_state_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic             ar_hs, r_oor;
  logic [AW-1:0]    ar_word;

  assign aw_word = awaddr_q >> 2;
  assign ar_word = raddr_q >> 2;
  assign w_oor   = RangeCheckEn && (aw_word >= AW'(C_MEMORY_SIZE));
  assign r_oor   = RangeCheckEn && (ar_word >= AW'(C_MEMORY_SIZE));

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_en_q  <= 1'b0;
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      out_en_q  <= 1'b1;
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write next-state
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if (aw_held_d && w_held_d) w_state_d = W_WRITE;
      end
      W_WRITE: begin
        // Out-of-range writes still pass through W_WRITE (with the pulse
        // suppressed) so the response latency matches in-range writes.
        w_state_d = W_RESP;
        bresp_d   = w_oor ? RESP_SLVERR : RESP_OKAY;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = RESP_OKAY;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write outputs
  always_comb begin
    s_axi_awready = out_en_q && (w_state_q == W_IDLE) && !aw_held_q;
    s_axi_wready  = out_en_q && (w_state_q == W_IDLE) && !w_held_q;
    s_axi_bvalid  = (w_state_q == W_RESP);
    s_axi_bresp   = bresp_q;
    mem_we        = (w_state_q == W_WRITE) && !w_oor;
    mem_be        = mem_we ? wstrb_q : '0;
    mem_waddr     = awaddr_q;
    mem_wdata     = wdata_q;
  end

  // Read next-state
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d   = s_axi_araddr;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        // Captured at the same edge a concurrent lane write lands, so a
        // colliding read returns the pre-write word.
        rdata_d   = r_oor ? '0 : mem_rdata;
        rresp_d   = r_oor ? RESP_SLVERR : RESP_OKAY;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_d = R_IDLE;
          rresp_d   = RESP_OKAY;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read outputs
  always_comb begin
    s_axi_arready = out_en_q && (r_state_q == R_IDLE);
    s_axi_rvalid  = (r_state_q == R_DATA);
    s_axi_rdata   = rdata_q;
    s_axi_rresp   = rresp_q;
    mem_raddr     = raddr_q;
  end

endmodule
